// File: rtl/por_seq_pkg.sv
// Shared types and sizing helpers for the power-on reset sequencer.
// Imported by the sequencer top and by any block that needs its state encoding.
package por_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STABLE   = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } por_state_e;

    localparam int unsigned DEF_NUM_DOMAINS   = 4;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 64;
    localparam int unsigned DEF_GAP_CYCLES    = 8;
    localparam int unsigned DEF_ACK_TIMEOUT   = 256;

    // One spare bit above the largest terminal count keeps the shared counter wrap-free.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles,
                                              input int unsigned gap_cycles,
                                              input int unsigned ack_timeout);
        int unsigned m;
        m = stable_cycles;
        if (gap_cycles > m) m = gap_cycles;
        if (ack_timeout > m) m = ack_timeout;
        return $clog2(m) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/por_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; output rises STAGES edges after release.
// Kept generic so downstream domain resets can reuse it.
module por_rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Releases NUM_DOMAINS core resets in index order after POR, with ack handshake and timeout.
//
//   state    | meaning
//   IDLE     | waiting for synchronised POR release
//   STABLE   | counting supply stabilisation cycles
//   RELEASE  | one cycle; releases RST_N_O[idx] on exit
//   WAIT_ACK | waiting for DOM_ACK_I[idx] or timeout
//   GAP      | idle cycles before the next domain release
//   DONE     | all domains released
module por_reset_sequencer
    import por_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic                   CLK_I,
    input  logic                   POR_N_I,
    input  logic                   SW_RST_REQ_I,
    input  logic [NUM_DOMAINS-1:0] DOM_ACK_I,
    output logic [NUM_DOMAINS-1:0] RST_N_O,
    output logic                   POR_DONE_O,
    output logic                   ACK_TIMEOUT_O,
    output logic [2:0]             STATE_O
);

    localparam int unsigned CW = cnt_width(STABLE_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
    localparam int unsigned IW = idx_width(NUM_DOMAINS);

    logic                   por_sync;
    por_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic                   flag_q, flag_d;
    logic                   ack_sel;

    por_rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_por_sync (
        .clk_i       (CLK_I),
        .rst_n_i     (POR_N_I),
        .rst_n_sync_o(por_sync)
    );

    always_ff @(posedge CLK_I or negedge POR_N_I) begin
        if (!POR_N_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        ack_sel = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IW'(i)) ack_sel = DOM_ACK_I[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        flag_d  = flag_q;

        // A software re-sequence overrides every other transition; the timeout flag survives it.
        if (SW_RST_REQ_I && (state_q != ST_IDLE)) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (por_sync) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                        state_d = ST_RELEASE;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IW'(i)) rst_n_d[i] = 1'b1;
                    end
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                end
                ST_WAIT_ACK: begin
                    if (ack_sel || (cnt_q == CW'(ACK_TIMEOUT - 1))) begin
                        if (!ack_sel) flag_d = 1'b1;
                        if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        state_d = ST_RELEASE;
                        idx_d   = idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign RST_N_O       = rst_n_q;
    assign POR_DONE_O    = done_q;
    assign ACK_TIMEOUT_O = flag_q;
    assign STATE_O       = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Self-checking bench for por_reset_sequencer: output-change events are matched
// against an expected-event queue, plus a minimal single-domain instance.
module tb_por_reset_sequencer;

    logic       clk = 1'b0;
    logic       por_n;
    logic       sw_req;
    logic [3:0] ack;
    logic [3:0] rst_n;
    logic       done;
    logic       flag;
    logic [2:0] state;

    logic       por2_n;
    logic       ack2;
    logic       rst2;
    logic       done2;
    logic       flag2;
    logic [2:0] state2;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int edge_base = 0;

    typedef struct {
        int         edge_no;
        logic [3:0] rst;
        logic       done;
        logic       flag;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic mon_en = 1'b0;
    logic mon_armed = 1'b0;
    logic [5:0] prev;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    por_reset_sequencer dut (
        .CLK_I        (clk),
        .POR_N_I      (por_n),
        .SW_RST_REQ_I (sw_req),
        .DOM_ACK_I    (ack),
        .RST_N_O      (rst_n),
        .POR_DONE_O   (done),
        .ACK_TIMEOUT_O(flag),
        .STATE_O      (state)
    );

    por_reset_sequencer #(
        .NUM_DOMAINS  (1),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1),
        .GAP_CYCLES   (1),
        .ACK_TIMEOUT  (1)
    ) dut_min (
        .CLK_I        (clk),
        .POR_N_I      (por2_n),
        .SW_RST_REQ_I (1'b0),
        .DOM_ACK_I    (ack2),
        .RST_N_O      (rst2),
        .POR_DONE_O   (done2),
        .ACK_TIMEOUT_O(flag2),
        .STATE_O      (state2)
    );

    // Records every change of the observable outputs, stamped with the edge count since release.
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_armed = 1'b0;
        end else if (!mon_armed) begin
            prev = {rst_n, done, flag};
            mon_armed = 1'b1;
        end else if ({rst_n, done, flag} !== prev) begin
            ev_t o;
            o.edge_no = edge_cnt - edge_base;
            o.rst     = rst_n;
            o.done    = done;
            o.flag    = flag;
            obs_q.push_back(o);
            prev = {rst_n, done, flag};
        end
    end

    task automatic push(input int e, input logic [3:0] r, input logic d, input logic f);
        ev_t x;
        x.edge_no = e;
        x.rst     = r;
        x.done    = d;
        x.flag    = f;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name, input int budget);
        int   waited = 0;
        ev_t  e;
        ev_t  o;
        while (exp_q.size() > 0) begin
            if (obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.edge_no !== e.edge_no || o.rst !== e.rst || o.done !== e.done || o.flag !== e.flag) begin
                    failures++;
                    $display("FAIL %s event: got edge=%0d rst=%b done=%b flag=%b, required edge=%0d rst=%b done=%b flag=%b",
                             name, o.edge_no, o.rst, o.done, o.flag, e.edge_no, e.rst, e.done, e.flag);
                end
            end else if (waited >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: %0d expected events still pending after %0d cycles", name, exp_q.size(), budget);
                exp_q.delete();
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        #1;
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL %s extra_events: got %0d unexpected output changes, required 0", name, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic por_assert();
        @(negedge clk);
        mon_en = 1'b0;
        por_n  = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic por_release();
        @(negedge clk);
        por_n     = 1'b1;
        edge_base = edge_cnt;
        mon_en    = 1'b1;
    endtask

    task automatic push_nominal();
        push(68, 4'b0001, 1'b0, 1'b0);
        push(78, 4'b0011, 1'b0, 1'b0);
        push(88, 4'b0111, 1'b0, 1'b0);
        push(98, 4'b1111, 1'b0, 1'b0);
        push(99, 4'b1111, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        por_n  = 1'b0;
        sw_req = 1'b0;
        ack    = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (rst_n !== 4'b0000) begin failures++; $display("FAIL reset_rst: got %b, required 0000", rst_n); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++;
        if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b, required 0", flag); end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", state); end
        // A software request while still held in IDLE must not disturb anything.
        sw_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0 || rst_n !== 4'b0000) begin
            failures++;
            $display("FAIL idle_sw_ignored: got state=%0d rst=%b, required state=0 rst=0000", state, rst_n);
        end
        sw_req = 1'b0;
    endtask

    task automatic test_nominal();
        ack = 4'hF;
        por_release();
        push_nominal();
        drain("nominal", 150);
        checks++;
        if (state !== 3'd5) begin failures++; $display("FAIL nominal_state: got %0d, required 5", state); end
    endtask

    task automatic test_por_pulse();
        por_assert();
        ack = 4'hF;
        por_release();
        push(68, 4'b0001, 1'b0, 1'b0);
        push(78, 4'b0011, 1'b0, 1'b0);
        drain("pulse_pre", 100);
        while (edge_cnt - edge_base < 80) @(negedge clk);
        checks++;
        if (state !== 3'd4) begin failures++; $display("FAIL pulse_in_gap: got state=%0d, required 4", state); end
        mon_en = 1'b0;
        #1 por_n = 1'b0;
        #1;
        checks++;
        if (rst_n !== 4'b0000 || state !== 3'd0 || flag !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL pulse_async: got rst=%b state=%0d flag=%b done=%b, required 0000/0/0/0", rst_n, state, flag, done);
        end
        repeat (3) @(negedge clk);
        obs_q.delete();
        por_release();
        push_nominal();
        drain("pulse_repeat", 150);
    endtask

    task automatic test_timeout();
        por_assert();
        ack = 4'b1101;
        por_release();
        push(68,  4'b0001, 1'b0, 1'b0);
        push(78,  4'b0011, 1'b0, 1'b0);
        push(334, 4'b0011, 1'b0, 1'b1);
        push(343, 4'b0111, 1'b0, 1'b1);
        push(353, 4'b1111, 1'b0, 1'b1);
        push(354, 4'b1111, 1'b1, 1'b1);
        drain("timeout", 400);
    endtask

    task automatic test_sw_in_done();
        mon_en = 1'b0;
        ack    = 4'b0111;
        @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk);
        checks++;
        if (rst_n !== 4'b0000 || done !== 1'b0 || state !== 3'd1 || flag !== 1'b1) begin
            failures++;
            $display("FAIL sw_done_entry: got rst=%b done=%b state=%0d flag=%b, required 0000/0/1/1", rst_n, done, state, flag);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (state !== 3'd1 || rst_n !== 4'b0000) begin
            failures++;
            $display("FAIL sw_hold: got state=%0d rst=%b, required 1/0000", state, rst_n);
        end
        sw_req    = 1'b0;
        edge_base = edge_cnt;
        obs_q.delete();
        mon_en    = 1'b1;
        push(65, 4'b0001, 1'b0, 1'b1);
        push(75, 4'b0011, 1'b0, 1'b1);
        push(85, 4'b0111, 1'b0, 1'b1);
        push(95, 4'b1111, 1'b0, 1'b1);
        drain("sw_resequence", 120);
        checks++;
        if (state !== 3'd3) begin failures++; $display("FAIL sw_wait_last: got state=%0d, required 3", state); end
    endtask

    task automatic test_sw_ack_collision();
        mon_en = 1'b0;
        @(negedge clk);
        ack    = 4'hF;
        sw_req = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || done !== 1'b0 || rst_n !== 4'b0000 || flag !== 1'b1) begin
            failures++;
            $display("FAIL sw_ack_collision: got state=%0d done=%b rst=%b flag=%b, required 1/0/0000/1", state, done, rst_n, flag);
        end
        sw_req = 1'b0;
    endtask

    task automatic test_single_domain();
        int rel;
        logic er;
        logic ef;
        ack2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rst2 !== 1'b0 || done2 !== 1'b0 || flag2 !== 1'b0 || state2 !== 3'd0) begin
            failures++;
            $display("FAIL min_reset: got rst=%b done=%b flag=%b state=%0d, required 0/0/0/0", rst2, done2, flag2, state2);
        end
        por2_n = 1'b1;
        rel    = edge_cnt;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            er = (edge_cnt - rel) >= 5;
            ef = (edge_cnt - rel) >= 6;
            checks++;
            if ({rst2, done2, flag2} !== {er, ef, ef}) begin
                failures++;
                $display("FAIL min_seq edge=%0d: got rst=%b done=%b flag=%b, required rst=%b done=%b flag=%b",
                         edge_cnt - rel, rst2, done2, flag2, er, ef, ef);
            end
        end
    endtask

    initial begin
        por_n  = 1'b0;
        por2_n = 1'b0;
        sw_req = 1'b0;
        ack    = 4'hF;
        ack2   = 1'b0;
        test_reset();
        test_nominal();
        test_por_pulse();
        test_timeout();
        test_sw_in_done();
        test_sw_ack_collision();
        test_single_domain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
